// File: rtl/rx_bit_deserialiser.sv
// Packs the LSB-first bit stream from the ISO 14443-3A frame decoder into bytes.
// Trailing partial bytes are reported at end-of-comms together with their bit count.
module rx_bit_deserialiser (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_soc,
   input  logic       in_eoc,
   input  logic       in_error,
   input  logic       in_data_valid,
   input  logic       in_data,
   output logic       out_soc,
   output logic       out_eoc,
   output logic       out_error,
   output logic       out_data_valid,
   output logic [7:0] out_data,
   output logic [2:0] out_data_bits
);

   logic [2:0] cnt;
   logic [7:0] sr;
   logic       err_seen;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt            <= '0;
         sr             <= '0;
         err_seen       <= 1'b0;
         out_soc        <= 1'b0;
         out_eoc        <= 1'b0;
         out_error      <= 1'b0;
         out_data_valid <= 1'b0;
         out_data       <= '0;
         out_data_bits  <= '0;
      end else begin
         out_soc        <= in_soc;
         out_eoc        <= in_eoc;
         out_error      <= in_error;
         out_data_valid <= 1'b0;

         if (in_soc) begin
            cnt      <= '0;
            sr       <= '0;
            err_seen <= in_error;
         end else if (in_eoc) begin
            // A coincident error drops the partial byte just like an earlier one.
            if (!err_seen && !in_error && (cnt != 3'd0)) begin
               out_data_valid <= 1'b1;
               out_data       <= sr;
               out_data_bits  <= cnt;
            end
            cnt      <= '0;
            sr       <= '0;
            err_seen <= 1'b0;
         end else if (in_error) begin
            cnt      <= '0;
            sr       <= '0;
            err_seen <= 1'b1;
         end else if (in_data_valid && !err_seen) begin
            if (cnt == 3'd7) begin
               out_data_valid <= 1'b1;
               out_data       <= {in_data, sr[6:0]};
               out_data_bits  <= '0;
               cnt            <= '0;
               sr             <= '0;
            end else begin
               sr[cnt] <= in_data;
               cnt     <= cnt + 3'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rx_bit_deserialiser.sv
// Scoreboard bench for rx_bit_deserialiser: a bit-list reference model queues expected
// output events with their due cycle; a negedge monitor pops and compares them.
module tb_rx_bit_deserialiser;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_soc = 1'b0, in_eoc = 1'b0, in_error = 1'b0;
   logic       in_data_valid = 1'b0, in_data = 1'b0;
   logic       out_soc, out_eoc, out_error, out_data_valid;
   logic [7:0] out_data;
   logic [2:0] out_data_bits;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc = 0;

   typedef struct {
      logic       soc, eoc, err, dv;
      logic [7:0] data;
      logic [2:0] bits;
      int unsigned due;
   } ev_t;

   ev_t sb[$];

   // reference model state: bits collected so far in the current word
   bit         mbits[$];
   bit         m_err = 1'b0;
   logic [7:0] last_data = 8'h00;
   logic [2:0] last_bits = 3'd0;

   rx_bit_deserialiser dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_soc         (in_soc),
      .in_eoc         (in_eoc),
      .in_error       (in_error),
      .in_data_valid  (in_data_valid),
      .in_data        (in_data),
      .out_soc        (out_soc),
      .out_eoc        (out_eoc),
      .out_error      (out_error),
      .out_data_valid (out_data_valid),
      .out_data       (out_data),
      .out_data_bits  (out_data_bits)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // monitor
   always @(negedge clk) begin
      ev_t e;
      if (rst_n) begin
         if (out_soc || out_eoc || out_error || out_data_valid) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event cyc=%0d got soc=%0b eoc=%0b err=%0b dv=%0b data=%02h bits=%0d required no event",
                        cyc, out_soc, out_eoc, out_error, out_data_valid, out_data, out_data_bits);
            end else begin
               e = sb.pop_front();
               if (e.due != cyc || {out_soc, out_eoc, out_error, out_data_valid} != {e.soc, e.eoc, e.err, e.dv}
                   || out_data != e.data || out_data_bits != e.bits) begin
                  errors++;
                  $display("FAIL event cyc=%0d got soc=%0b eoc=%0b err=%0b dv=%0b data=%02h bits=%0d required cyc=%0d soc=%0b eoc=%0b err=%0b dv=%0b data=%02h bits=%0d",
                           cyc, out_soc, out_eoc, out_error, out_data_valid, out_data, out_data_bits,
                           e.due, e.soc, e.eoc, e.err, e.dv, e.data, e.bits);
               end
            end
         end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            checks++;
            errors++;
            e = sb.pop_front();
            $display("FAIL missing_event cyc=%0d got no event required soc=%0b eoc=%0b err=%0b dv=%0b data=%02h bits=%0d",
                     cyc, e.soc, e.eoc, e.err, e.dv, e.data, e.bits);
         end
      end
   end

   task automatic step(input logic s, input logic e, input logic er, input logic v, input logic d);
      @(posedge clk);
      #1;
      in_soc = s; in_eoc = e; in_error = er; in_data_valid = v; in_data = d;
   endtask

   task automatic push(input logic s, input logic e, input logic er, input logic v,
                       input logic [7:0] data, input logic [2:0] bits);
      ev_t x;
      if (v) begin
         last_data = data;
         last_bits = bits;
      end
      x.soc = s; x.eoc = e; x.err = er; x.dv = v;
      x.data = last_data; x.bits = last_bits; x.due = cyc + 1;
      sb.push_back(x);
   endtask

   function automatic logic [7:0] pack_bits();
      logic [7:0] b = 8'h00;
      for (int i = 0; i < mbits.size(); i++) b[i] = mbits[i];
      return b;
   endfunction

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom));
   endtask

   task automatic do_soc();
      // a data bit alongside soc must be ignored
      step(1'b1, 1'b0, 1'b0, 1'($urandom), 1'($urandom));
      push(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0);
      mbits.delete();
      m_err = 1'b0;
   endtask

   task automatic do_bit(input bit b);
      step(1'b0, 1'b0, 1'b0, 1'b1, b);
      if (!m_err) begin
         mbits.push_back(b);
         if (mbits.size() == 8) begin
            push(1'b0, 1'b0, 1'b0, 1'b1, pack_bits(), 3'd0);
            mbits.delete();
         end
      end
   endtask

   task automatic do_err();
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'($urandom));
      push(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
      m_err = 1'b1;
      mbits.delete();
   endtask

   task automatic do_eoc(input bit er);
      step(1'b0, 1'b1, er, 1'($urandom), 1'($urandom));
      if (!m_err && !er && mbits.size() > 0)
         push(1'b0, 1'b1, 1'b0, 1'b1, pack_bits(), 3'(mbits.size()));
      else
         push(1'b0, 1'b1, er, 1'b0, 8'h00, 3'd0);
      mbits.delete();
      m_err = 1'b0;
   endtask

   task automatic maybe_gap(input bit gaps);
      if (gaps && ($urandom_range(0, 3) == 0)) idle();
   endtask

   task automatic run_frame(input logic [79:0] bits, input int n, input int err_at,
                            input bit eoc_err, input bit gaps);
      do_soc();
      maybe_gap(gaps);
      for (int i = 0; i < n; i++) begin
         if (i == err_at) do_err();
         do_bit(bits[i]);
         maybe_gap(gaps);
      end
      do_eoc(eoc_err);
      maybe_gap(gaps);
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if ({out_soc, out_eoc, out_error, out_data_valid, out_data, out_data_bits} != 15'd0) begin
         errors++;
         $display("FAIL %s got soc=%0b eoc=%0b err=%0b dv=%0b data=%02h bits=%0d required all zero",
                  name, out_soc, out_eoc, out_error, out_data_valid, out_data, out_data_bits);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 4; i++) idle();
   endtask

   initial begin
      logic [79:0] rbits;
      logic [79:0] a5;
      int n, err_at;
      bit eoc_err;

      repeat (2) @(negedge clk);
      check_all_zero("reset_state");
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle();

      run_frame(80'h4D, 8, -1, 1'b0, 1'b0);
      drain();

      a5 = 80'hA5;
      for (int k = 1; k <= 7; k++) begin
         run_frame(a5, k, -1, 1'b0, 1'b0);
      end
      drain();

      // error before bit 11 of a 20-bit frame; later bits must be suppressed
      run_frame({$urandom(), $urandom(), $urandom()}, 20, 11, 1'b0, 1'b0);
      // error coincident with eoc of a 13-bit frame
      run_frame({$urandom(), $urandom(), $urandom()}, 13, -1, 1'b1, 1'b0);
      drain();

      // reset mid-frame after 5 bits
      do_soc();
      for (int i = 0; i < 5; i++) do_bit(1'b1);
      idle();
      @(posedge clk);
      #1 rst_n = 1'b0;
      mbits.delete();
      m_err = 1'b0;
      last_data = 8'h00;
      last_bits = 3'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_all_zero("in_reset");
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      run_frame(80'h3C, 8, -1, 1'b0, 1'b0);
      drain();

      for (int f = 0; f < 1000; f++) begin
         rbits = {$urandom(), $urandom(), $urandom()};
         n = $urandom_range(1, 80);
         err_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, n - 1)) : -1;
         eoc_err = ($urandom_range(0, 9) == 0);
         run_frame(rbits, n, err_at, eoc_err, 1'b1);
      end
      drain();

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_empty got %0d pending required 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
